// File: rtl/run_ctl_if.sv
// run_ctl_if: front panel and bus requests going into the run controller,
// and the phase clocks and status it drives back out.
interface run_ctl_if;
    logic        nhalt;
    logic        nws;
    logic        fprun;
    logic        fpstep;
    logic        clk1;
    logic        clk2;
    logic        clk3;
    logic        clk4;
    logic        t34;
    logic        nrsthold;
    logic        running;
    logic        nhalted;
    logic [15:0] ucount;
    logic        ws_timeout;

    modport master (
        output nhalt, nws, fprun, fpstep,
        input  clk1, clk2, clk3, clk4, t34, nrsthold, running, nhalted, ucount, ws_timeout
    );

    modport slave (
        input  nhalt, nws, fprun, fpstep,
        output clk1, clk2, clk3, clk4, t34, nrsthold, running, nhalted, ucount, ws_timeout
    );
endinterface

// File: rtl/run_ctl.sv
// run_ctl: CTL board processor run controller. Divides the master clock into
// processor phases T1..T4, holds nrsthold low after reset, and sequences
// RUN / STEP / STOPPED from the front panel, nhalt and nws.
// Optional feature: define RUN_CTL_WS_TIMEOUT_EN to bound wait-state
// stretching at WS_TIMEOUT cycles and pulse ws_timeout on a forced release.
module run_ctl #(
    parameter int unsigned RSTHOLD_CYCLES = 16,
    parameter int unsigned WS_TIMEOUT     = 64
) (
    input  logic      clk,
    input  logic      reset,
    run_ctl_if.slave  bus
);
    typedef enum logic [1:0] {S_HOLD, S_STOPPED, S_RUN, S_STEP} state_t;
    typedef enum logic [1:0] {PH_T1, PH_T2, PH_T3, PH_T4} phase_t;

    localparam int unsigned HOLD_W = (RSTHOLD_CYCLES < 1) ? 1 : $clog2(RSTHOLD_CYCLES + 1);

    if (RSTHOLD_CYCLES < 1 || WS_TIMEOUT < 1) begin : g_param_check
        $error("run_ctl: RSTHOLD_CYCLES and WS_TIMEOUT must be at least 1");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    phase_t              r_phase;
    phase_t              w_phase_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_nxt;
    logic                r_nrsthold;
    logic                w_nrsthold_nxt;
    logic                r_nhalted;
    logic                w_nhalted_nxt;
    logic [15:0]         r_ucount;
    logic [15:0]         w_ucount_nxt;
    logic                w_ws_force;
    logic                w_active_nxt;
    logic                r_clk1;
    logic                r_clk2;
    logic                r_clk3;
    logic                r_clk4;
    logic                r_t34;
    logic                r_running;

    // State, phase and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_HOLD;
            r_phase    <= PH_T1;
            r_hold_cnt <= '0;
            r_nrsthold <= 1'b0;
            r_nhalted  <= 1'b1;
            r_ucount   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_nrsthold <= w_nrsthold_nxt;
            r_nhalted  <= w_nhalted_nxt;
            r_ucount   <= w_ucount_nxt;
        end
    end

    // Next state, phase and counters; stop decisions are taken only at the end of T4
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_hold_cnt_nxt = r_hold_cnt;
        w_nrsthold_nxt = r_nrsthold;
        w_nhalted_nxt  = r_nhalted;
        w_ucount_nxt   = r_ucount;
        case (r_state)
            S_HOLD: begin
                w_phase_nxt = PH_T1;
                if (r_hold_cnt == HOLD_W'(RSTHOLD_CYCLES)) begin
                    w_state_nxt    = S_STOPPED;
                    w_nrsthold_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            S_STOPPED: begin
                w_phase_nxt = PH_T1;
                if (bus.fprun && bus.nhalt) begin
                    w_state_nxt   = S_RUN;
                    w_nhalted_nxt = 1'b1;
                end else if (bus.fpstep) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_RUN, S_STEP: begin
                case (r_phase)
                    PH_T1: w_phase_nxt = PH_T2;
                    PH_T2: w_phase_nxt = PH_T3;
                    PH_T3: begin
                        if (bus.nws || w_ws_force) begin
                            w_phase_nxt = PH_T4;
                        end
                    end
                    PH_T4: begin
                        w_ucount_nxt = r_ucount + 16'd1;
                        w_phase_nxt  = PH_T1;
                        if (r_state == S_STEP || !bus.fprun || !bus.nhalt) begin
                            w_state_nxt = S_STOPPED;
                            if (r_state == S_RUN && !bus.nhalt) begin
                                w_nhalted_nxt = 1'b0;
                            end
                        end
                    end
                    default: w_phase_nxt = PH_T1;
                endcase
            end
            default: begin
                w_state_nxt = S_HOLD;
                w_phase_nxt = PH_T1;
            end
        endcase
    end

    assign w_active_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);

    // Phase clocks and run status, decoded from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk1    <= 1'b0;
            r_clk2    <= 1'b0;
            r_clk3    <= 1'b0;
            r_clk4    <= 1'b0;
            r_t34     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_clk1    <= w_active_nxt && (w_phase_nxt == PH_T1);
            r_clk2    <= w_active_nxt && (w_phase_nxt == PH_T2);
            r_clk3    <= w_active_nxt && (w_phase_nxt == PH_T3);
            r_clk4    <= w_active_nxt && (w_phase_nxt == PH_T4);
            r_t34     <= w_active_nxt && ((w_phase_nxt == PH_T3) || (w_phase_nxt == PH_T4));
            r_running <= (w_state_nxt == S_RUN);
        end
    end

`ifdef RUN_CTL_WS_TIMEOUT_EN
    localparam int unsigned WS_W = $clog2(WS_TIMEOUT + 1);

    logic [WS_W-1:0] r_ws_cnt;
    logic            r_ws_timeout;

    assign w_ws_force = (r_phase == PH_T3) && !bus.nws && (r_ws_cnt == WS_W'(WS_TIMEOUT));

    // Count consecutive stretched T3 cycles; held at zero outside T3 so every T3 entry starts clean
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ws_cnt     <= '0;
            r_ws_timeout <= 1'b0;
        end else begin
            r_ws_timeout <= w_ws_force;
            if (r_phase != PH_T3) begin
                r_ws_cnt <= '0;
            end else if (!bus.nws && !w_ws_force) begin
                r_ws_cnt <= r_ws_cnt + 1'b1;
            end
        end
    end

    assign bus.ws_timeout = r_ws_timeout;
`else
    assign w_ws_force     = 1'b0;
    assign bus.ws_timeout = 1'b0;
`endif

    assign bus.clk1     = r_clk1;
    assign bus.clk2     = r_clk2;
    assign bus.clk3     = r_clk3;
    assign bus.clk4     = r_clk4;
    assign bus.t34      = r_t34;
    assign bus.nrsthold = r_nrsthold;
    assign bus.running  = r_running;
    assign bus.nhalted  = r_nhalted;
    assign bus.ucount   = r_ucount;
endmodule

// File: tb/tb_run_ctl.sv
// tb_run_ctl: self-checking bench for run_ctl. A vector table covers start,
// stop, step, halt and a short wait state; hand sequences cover reset hold
// timing, long wait stretching and asynchronous reset mid-cycle; a random
// phase is checked against a behavioural model of the run rules.
module tb_run_ctl;
    localparam int unsigned RST_N = 16;
    localparam int unsigned WS_N  = 64;
    localparam int          N_VEC = 27;
    localparam int          N_RND = 3000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    run_ctl_if bus ();

    run_ctl #(
        .RSTHOLD_CYCLES (RST_N),
        .WS_TIMEOUT     (WS_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  in;   // {fprun, nhalt, nws, fpstep}
        logic [3:0]  ph;   // {clk1, clk2, clk3, clk4}
        logic [2:0]  fl;   // {t34, running, nhalted}
        logic [15:0] uc;
    } vec_t;

    vec_t tbl [N_VEC];

    function automatic vec_t mk(logic [3:0] in, logic [3:0] ph, logic [2:0] fl, int uc);
        vec_t v;
        v.in = in;
        v.ph = ph;
        v.fl = fl;
        v.uc = 16'(uc);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {clk1..clk4, t34, nrsthold, running, nhalted, ws_timeout, ucount}
    function automatic logic [31:0] dut_vec();
        return 32'({bus.clk1, bus.clk2, bus.clk3, bus.clk4, bus.t34, bus.nrsthold,
                    bus.running, bus.nhalted, bus.ws_timeout, bus.ucount});
    endfunction

    localparam logic [31:0] RESET_VEC = 32'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});

    // Behavioural model: tracks whether the processor is mid-cycle, which
    // phase number (1..4) it is in, and the counters the front panel sees.
    bit m_up, m_active, m_single, m_halted, m_wst;
    int m_edges, m_ph, m_stretch, m_uc;

    function automatic void model_reset();
        m_up = 0; m_active = 0; m_single = 0; m_halted = 0; m_wst = 0;
        m_edges = 0; m_ph = 1; m_stretch = 0; m_uc = 0;
    endfunction

    function automatic void model_edge(bit fprun, bit nhalt, bit nws, bit fpstep);
        bit forced;
        m_wst = 0;
        if (!m_up) begin
            m_edges++;
            if (m_edges > RST_N) m_up = 1;
            return;
        end
        if (!m_active) begin
            if (fprun && nhalt) begin
                m_active = 1; m_single = 0; m_ph = 1; m_halted = 0;
            end else if (fpstep) begin
                m_active = 1; m_single = 1; m_ph = 1;
            end
            return;
        end
        case (m_ph)
            1: m_ph = 2;
            2: begin m_ph = 3; m_stretch = 0; end
            3: begin
`ifdef RUN_CTL_WS_TIMEOUT_EN
                forced = (m_stretch == WS_N);
`else
                forced = 0;
`endif
                if (nws) m_ph = 4;
                else if (forced) begin m_ph = 4; m_wst = 1; end
                else m_stretch++;
            end
            default: begin
                m_uc = (m_uc + 1) % 65536;
                if (m_single) m_active = 0;
                else if (fprun && nhalt) m_ph = 1;
                else begin
                    m_active = 0;
                    if (!nhalt) m_halted = 1;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] model_vec();
        return 32'({m_active && m_ph == 1, m_active && m_ph == 2, m_active && m_ph == 3,
                    m_active && m_ph == 4, m_active && m_ph >= 3, m_up,
                    m_active && !m_single, !m_halted, m_wst, 16'(m_uc)});
    endfunction

    int rise, first, len, pulses, n, bad;
    logic [3:0] pat;
    bit r_fr, r_nh, r_nw, r_fs;

    initial begin
        // Rows start in STOPPED with ucount 0; each row is applied then one edge taken.
        tbl[0]  = mk(4'b1110, 4'b1000, 3'b011, 0);
        tbl[1]  = mk(4'b1110, 4'b0100, 3'b011, 0);
        tbl[2]  = mk(4'b1110, 4'b0010, 3'b111, 0);
        tbl[3]  = mk(4'b1110, 4'b0001, 3'b111, 0);
        tbl[4]  = mk(4'b1110, 4'b1000, 3'b011, 1);
        tbl[5]  = mk(4'b0110, 4'b0100, 3'b011, 1);
        tbl[6]  = mk(4'b0110, 4'b0010, 3'b111, 1);
        tbl[7]  = mk(4'b0110, 4'b0001, 3'b111, 1);
        tbl[8]  = mk(4'b0110, 4'b0000, 3'b001, 2);
        tbl[9]  = mk(4'b0111, 4'b1000, 3'b001, 2);
        tbl[10] = mk(4'b0111, 4'b0100, 3'b001, 2);
        tbl[11] = mk(4'b0100, 4'b0010, 3'b101, 2);
        tbl[12] = mk(4'b0100, 4'b0010, 3'b101, 2);
        tbl[13] = mk(4'b0110, 4'b0001, 3'b101, 2);
        tbl[14] = mk(4'b0110, 4'b0000, 3'b001, 3);
        tbl[15] = mk(4'b1010, 4'b0000, 3'b001, 3);
        tbl[16] = mk(4'b1110, 4'b1000, 3'b011, 3);
        tbl[17] = mk(4'b1010, 4'b0100, 3'b011, 3);
        tbl[18] = mk(4'b1010, 4'b0010, 3'b111, 3);
        tbl[19] = mk(4'b1110, 4'b0001, 3'b111, 3);
        tbl[20] = mk(4'b1010, 4'b0000, 3'b000, 4);
        tbl[21] = mk(4'b1011, 4'b1000, 3'b000, 4);
        tbl[22] = mk(4'b1010, 4'b0100, 3'b000, 4);
        tbl[23] = mk(4'b1010, 4'b0010, 3'b100, 4);
        tbl[24] = mk(4'b1010, 4'b0001, 3'b100, 4);
        tbl[25] = mk(4'b1010, 4'b0000, 3'b000, 5);
        tbl[26] = mk(4'b1110, 4'b1000, 3'b011, 5);

        bus.fprun = 1'b0; bus.nhalt = 1'b1; bus.nws = 1'b1; bus.fpstep = 1'b0;

        // Power-on reset and hold interval
        #1 reset = 1'b1;
        #11;
        chk("por_reset_values", dut_vec(), RESET_VEC);
        @(posedge clk); #1; reset = 1'b0;
        rise = 0; bad = 0;
        for (int e = 1; e <= int'(RST_N) + 8 && rise == 0; e++) begin
            tick();
            if (bus.clk1 || bus.clk2 || bus.clk3 || bus.clk4 || bus.t34) bad++;
            if (bus.nrsthold) rise = e;
        end
        chk("hold_edges_to_nrsthold", rise, RST_N + 1);
        chk("hold_phases_idle", bad, 0);

        // Vector table
        for (int i = 0; i < N_VEC; i++) begin
            {bus.fprun, bus.nhalt, bus.nws, bus.fpstep} = tbl[i].in;
            tick();
            chk($sformatf("vec%0d_phases", i), {bus.clk1, bus.clk2, bus.clk3, bus.clk4}, tbl[i].ph);
            chk($sformatf("vec%0d_flags", i), {bus.t34, bus.running, bus.nhalted}, tbl[i].fl);
            chk($sformatf("vec%0d_ucount", i), bus.ucount, tbl[i].uc);
            chk($sformatf("vec%0d_ws_timeout", i), bus.ws_timeout, 1'b0);
        end

        // Five sampled wait states stretch T3 to six cycles
        bus.fprun = 1'b1; bus.nhalt = 1'b1; bus.nws = 1'b1;
        tick();
        chk("ws5_t2", bus.clk2, 1'b1);
        bus.nws = 1'b0;
        tick();
        len = (bus.clk3 && bus.t34) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.clk3 && bus.t34) len++;
        end
        bus.nws = 1'b1;
        tick();
        chk("ws5_t3_length", len, 6);
        chk("ws5_then_t4", {bus.clk3, bus.clk4, bus.t34}, 3'b011);
        tick();
        chk("ws5_ucount", bus.ucount, 16'd6);
        chk("ws5_back_to_t1", bus.clk1, 1'b1);

`ifdef RUN_CTL_WS_TIMEOUT_EN
        // Permanent wait request: T4 forced after WS_N stretched cycles, one pulse each
        bus.nws = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n = 0;
            while (!bus.clk3 && n < 10) begin tick(); n++; end
            len = 0; pulses = 0;
            while (bus.clk3 && len < 200) begin
                len++;
                tick();
                pulses += int'(bus.ws_timeout);
            end
            chk($sformatf("wsto%0d_t3_length", c), len, WS_N + 1);
            chk($sformatf("wsto%0d_forced_t4", c), {bus.clk4, bus.ws_timeout}, 2'b11);
            tick();
            pulses += int'(bus.ws_timeout);
            chk($sformatf("wsto%0d_pulse_count", c), pulses, 1);
        end
        bus.nws = 1'b1;
`else
        // Without the timeout a held wait request stretches T3 indefinitely
        n = 0;
        while (!bus.clk3 && n < 10) begin tick(); n++; end
        chk("stretch_reach_t3", bus.clk3, 1'b1);
        bus.nws = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!bus.clk3 || !bus.t34 || bus.ws_timeout) bad++;
        end
        chk("stretch_unbounded", bad, 0);
        bus.nws = 1'b1;
        tick();
        chk("stretch_release_t4", {bus.clk4, bus.ws_timeout}, 2'b10);
`endif

        // Asynchronous reset in the middle of T3, then restart with fprun held
        bus.fprun = 1'b1; bus.nhalt = 1'b1; bus.nws = 1'b1;
        n = 0;
        while (!bus.clk3 && n < 10) begin tick(); n++; end
        chk("areset_reach_t3", bus.clk3, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk("areset_values", dut_vec(), RESET_VEC);
        @(posedge clk); #1;
        chk("areset_held", dut_vec(), RESET_VEC);
        reset = 1'b0;
        rise = 0; first = 0;
        for (int e = 1; e <= int'(RST_N) + 10 && first == 0; e++) begin
            tick();
            if (bus.nrsthold && rise == 0) rise = e;
            if (bus.clk1) first = e;
        end
        chk("restart_nrsthold_edge", rise, RST_N + 1);
        chk("restart_first_clk1_edge", first, RST_N + 2);
        pat = 4'b1000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("restart_seq%0d", k), {bus.clk1, bus.clk2, bus.clk3, bus.clk4, bus.t34},
                {pat >> (k % 4), (k % 4) >= 2});
        end

        // Randomized run against the behavioural model
        reset = 1'b1;
        model_reset();
        #2;
        chk("rand_reset_values", dut_vec(), model_vec());
        @(posedge clk); #1;
        reset = 1'b0;
        r_fr = 1'b0; r_nh = 1'b1;
        for (int i = 0; i < N_RND; i++) begin
            if ($urandom_range(99) < 5) r_fr = ~r_fr;
            if ($urandom_range(99) < 5) r_nh = ~r_nh;
            r_nw = ($urandom_range(99) >= 25);
            r_fs = ($urandom_range(99) < 10);
            bus.fprun = r_fr; bus.nhalt = r_nh; bus.nws = r_nw; bus.fpstep = r_fs;
            tick();
            model_edge(r_fr, r_nh, r_nw, r_fs);
            chk($sformatf("rand%0d_outputs", i), dut_vec(), model_vec());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
